// File: rtl/cache_ctrl.sv
// -----------------------------------------------------------------------------
// cache_ctrl
// Direct-mapped, one-word-per-line cache controller. Loads allocate on a miss.
// Stores are write-through and do not allocate. Hit and miss counters
// saturate at 16'hFFFF.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata    CPU request, held stable until cpu_ready
//   cpu_rdata, cpu_ready     load data and one-cycle completion pulse
//   mem_req/we/addr/wdata    memory request, held until mem_ready
//   mem_rdata, mem_ready     memory read data and completion
//   hit_count, miss_count    saturating access statistics
// -----------------------------------------------------------------------------
module cache_ctrl #(
   parameter int INDEX_W = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [31:0] cpu_addr,
   input  logic [31:0] cpu_wdata,
   output logic [31:0] cpu_rdata,
   output logic        cpu_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready,
   output logic [15:0] hit_count,
   output logic [15:0] miss_count
);

   localparam int LINES = 1 << INDEX_W;
   localparam int TAG_W = 30 - INDEX_W;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOOKUP = 3'd1,
      MEM_RD = 3'd2,
      MEM_WR = 3'd3,
      RESP   = 3'd4
   } state_t;

   state_t             state_q, state_d;
   logic [29:0]        word_q, word_d;        // latched word address
   logic               we_q, we_d;
   logic [31:0]        wdata_q, wdata_d;
   logic [31:0]        cpu_rdata_q, cpu_rdata_d;
   logic [31:0]        mem_addr_q, mem_addr_d;
   logic [31:0]        mem_wdata_q, mem_wdata_d;
   logic [15:0]        hit_q, hit_d;
   logic [15:0]        miss_q, miss_d;
   logic [LINES-1:0]   valid_q;

   // Tag and data arrays: plain RAM, registered read, never reset.
   logic [TAG_W-1:0]   tag_mem  [LINES];
   logic [31:0]        data_mem [LINES];
   logic [TAG_W-1:0]   tag_rd_q;
   logic [31:0]        data_rd_q;

   logic               data_we;
   logic               tag_we;
   logic               valid_set;
   logic [31:0]        wr_data;

   logic [INDEX_W-1:0] idx_q;
   logic [TAG_W-1:0]   tag_q;
   logic [INDEX_W-1:0] cpu_idx;
   logic               hit;
   logic               unused_addr_bits;

   assign idx_q            = word_q[INDEX_W-1:0];
   assign tag_q            = word_q[29:INDEX_W];
   assign cpu_idx          = cpu_addr[INDEX_W+1:2];
   assign unused_addr_bits = ^cpu_addr[1:0];

   // The arrays are read every cycle with the live CPU index. The read
   // taken in the IDLE cycle that samples the request is what LOOKUP sees.
   // No array write can happen in IDLE, so that read is never stale.
   assign hit = valid_q[idx_q] && (tag_rd_q == tag_q);

   always_comb begin
      state_d     = state_q;
      word_d      = word_q;
      we_d        = we_q;
      wdata_d     = wdata_q;
      cpu_rdata_d = cpu_rdata_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      hit_d       = hit_q;
      miss_d      = miss_q;
      data_we     = 1'b0;
      tag_we      = 1'b0;
      valid_set   = 1'b0;
      wr_data     = mem_rdata;

      case (state_q)
         IDLE: begin
            if (cpu_req) begin
               state_d = LOOKUP;
               word_d  = cpu_addr[31:2];
               we_d    = cpu_we;
               wdata_d = cpu_wdata;
            end
         end
         LOOKUP: begin
            if (hit) begin
               hit_d = (hit_q == 16'hFFFF) ? hit_q : hit_q + 16'd1;
            end else begin
               miss_d = (miss_q == 16'hFFFF) ? miss_q : miss_q + 16'd1;
            end
            if (we_q) begin
               state_d     = MEM_WR;
               mem_addr_d  = {word_q, 2'b00};
               mem_wdata_d = wdata_q;
               if (hit) begin
                  data_we = 1'b1;
                  wr_data = wdata_q;
               end
            end else if (hit) begin
               state_d     = RESP;
               cpu_rdata_d = data_rd_q;
            end else begin
               state_d    = MEM_RD;
               mem_addr_d = {word_q, 2'b00};
            end
         end
         MEM_RD: begin
            if (mem_ready) begin
               data_we     = 1'b1;
               tag_we      = 1'b1;
               valid_set   = 1'b1;
               cpu_rdata_d = mem_rdata;
               state_d     = RESP;
            end
         end
         MEM_WR: begin
            if (mem_ready) begin
               state_d = RESP;
            end
         end
         RESP: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         word_q      <= '0;
         we_q        <= 1'b0;
         wdata_q     <= '0;
         cpu_rdata_q <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         hit_q       <= '0;
         miss_q      <= '0;
         valid_q     <= '0;
      end else begin
         state_q     <= state_d;
         word_q      <= word_d;
         we_q        <= we_d;
         wdata_q     <= wdata_d;
         cpu_rdata_q <= cpu_rdata_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         hit_q       <= hit_d;
         miss_q      <= miss_d;
         if (valid_set) begin
            valid_q[idx_q] <= 1'b1;
         end
      end
   end

   // Array writes are gated by state_q. An asynchronous reset forces IDLE,
   // so an abandoned fill can never write a line.
   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[idx_q] <= wr_data;
      end
      if (tag_we) begin
         tag_mem[idx_q] <= tag_q;
      end
      tag_rd_q  <= tag_mem[cpu_idx];
      data_rd_q <= data_mem[cpu_idx];
   end

   assign cpu_ready  = (state_q == RESP);
   assign mem_req    = (state_q == MEM_RD) || (state_q == MEM_WR);
   assign mem_we     = (state_q == MEM_WR);
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign hit_count  = hit_q;
   assign miss_count = miss_q;

endmodule

// File: tb/tb_cache_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cache_ctrl
// Self-checking bench for cache_ctrl. A reference model holds a map of
// index -> cached word address/data and a sparse memory image. Each access
// is predicted from those maps, then driven with a cycle-accurate memory
// responder.
// -----------------------------------------------------------------------------
module tb_cache_ctrl;

   localparam int INDEX_W = 8;
   localparam int LINES   = 1 << INDEX_W;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cpu_req, cpu_we;
   logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic        cpu_ready;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_ready;
   logic [15:0] hit_count, miss_count;

   cache_ctrl #(.INDEX_W(INDEX_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_rdata  (cpu_rdata),
      .cpu_ready  (cpu_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .mem_ready  (mem_ready),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int txn   = 0;

   // Reference model
   logic [31:0] mem_model [int unsigned];
   int unsigned line_word [int unsigned];
   logic [31:0] line_val  [int unsigned];
   int          exp_hits   = 0;
   int          exp_misses = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] mem_read(input int unsigned w);
      if (mem_model.exists(w)) return mem_model[w];
      return (w * 32'h9E37_79B9) ^ 32'h1234_5678;
   endfunction

   task automatic finish_up();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   endtask

   // One CPU access. lat = cycle of mem_req in which mem_ready is returned.
   task automatic access(input bit we, input logic [31:0] addr,
                         input logic [31:0] wdata, input int lat);
      int unsigned w;
      int unsigned idx;
      bit          hit;
      logic [31:0] ret;
      logic [31:0] exp_rdata;
      int          exp_lat;
      int          exp_memcyc;
      int          cyc;
      int          memcyc;
      bit          done;

      w   = addr[31:2];
      idx = w % LINES;
      hit = line_word.exists(idx) && (line_word[idx] == w);
      ret = mem_read(w);

      if (hit) begin
         if (exp_hits < 65535) exp_hits++;
      end else begin
         if (exp_misses < 65535) exp_misses++;
      end
      exp_rdata  = 32'h0;
      if (we) begin
         if (hit) line_val[idx] = wdata;
         mem_model[w] = wdata;
      end else if (hit) begin
         exp_rdata = line_val[idx];
      end else begin
         exp_rdata      = ret;
         line_word[idx] = w;
         line_val[idx]  = ret;
      end
      exp_lat    = (!we && hit) ? 2 : 2 + lat;
      exp_memcyc = (!we && hit) ? 0 : lat;

      @(posedge clk);
      #1;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cyc    = 0;
      memcyc = 0;
      done   = 1'b0;
      while (!done && cyc < 60) begin
         @(posedge clk);
         cyc++;
         #1;
         // Request is already latched; these changes must be ignored.
         cpu_addr  = $urandom;
         cpu_wdata = $urandom;
         cpu_we    = 1'($urandom);
         @(negedge clk);
         if (mem_req) begin
            memcyc++;
            check_val("mem_we", {31'b0, mem_we}, {31'b0, we});
            check_val("mem_addr", mem_addr, {addr[31:2], 2'b00});
            if (we) check_val("mem_wdata", mem_wdata, wdata);
            if (memcyc == lat) begin
               mem_ready = 1'b1;
               mem_rdata = we ? $urandom : ret;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
         end else begin
            // Noise on the memory side while no request is pending.
            mem_ready = 1'($urandom);
            mem_rdata = $urandom;
         end
         if (cpu_ready) begin
            done = 1'b1;
            check_val("latency", cyc, exp_lat);
            if (!we) check_val("cpu_rdata", cpu_rdata, exp_rdata);
            check_val("mem_cycles", memcyc, exp_memcyc);
            check_val("hit_count", {16'b0, hit_count}, exp_hits);
            check_val("miss_count", {16'b0, miss_count}, exp_misses);
            cpu_req   = 1'b0;
            mem_ready = 1'b0;
            $display("txn %0d %s addr=%h wdata=%h hit=%0d lat=%0d rdata=%h hits=%0d misses=%0d",
                     txn, we ? "SW" : "LW", addr, wdata, hit, cyc, cpu_rdata,
                     hit_count, miss_count);
         end
      end
      txn++;
      if (!done) begin
         check_val("ready_timeout", 32'd0, 32'd1);
         finish_up();
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      cpu_req   = 1'b0;
      cpu_we    = 1'b0;
      cpu_addr  = '0;
      cpu_wdata = '0;
      mem_rdata = '0;
      mem_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_val("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
      check_val("rst_mem_req", {31'b0, mem_req}, 32'd0);
      check_val("rst_mem_we", {31'b0, mem_we}, 32'd0);
      check_val("rst_cpu_rdata", cpu_rdata, 32'd0);
      check_val("rst_mem_addr", mem_addr, 32'd0);
      check_val("rst_mem_wdata", mem_wdata, 32'd0);
      check_val("rst_hits", {16'b0, hit_count}, 32'd0);
      check_val("rst_misses", {16'b0, miss_count}, 32'd0);
      rst_n = 1'b1;

      // Directed scenarios
      mem_model[32'h3]   = 32'h4;
      mem_model[32'h403] = 32'h99;
      access(1'b0, 32'h0000_000C, 32'h0, 2);   // cold miss, rdata 4
      access(1'b0, 32'h0000_000C, 32'h0, 2);   // hit
      access(1'b0, 32'h0000_100C, 32'h0, 2);   // conflict miss, 0x99
      access(1'b0, 32'h0000_000C, 32'h0, 2);   // conflict miss again
      access(1'b1, 32'h0000_000C, 32'h3, 2);   // write-through hit
      access(1'b0, 32'h0000_000C, 32'h0, 1);   // hit, rdata 3
      access(1'b1, 32'h0000_200C, 32'h7, 2);   // store miss, no allocate
      access(1'b0, 32'h0000_200C, 32'h0, 3);   // still misses, returns 7

      // Randomized traffic over a small footprint to force hits and conflicts
      for (int i = 0; i < 150; i++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
         access(($urandom_range(0, 2) == 0), a, $urandom, $urandom_range(1, 4));
      end

      // Reset in the middle of a read miss
      access(1'b0, 32'h0000_1C04, 32'h0, 1);
      access(1'b0, 32'h0000_1C04, 32'h0, 1);
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 32'h0000_2C04;
      @(posedge clk);
      @(posedge clk);
      #1;
      check_val("mid_mem_req", {31'b0, mem_req}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_val("abort_mem_req", {31'b0, mem_req}, 32'd0);
      check_val("abort_cpu_ready", {31'b0, cpu_ready}, 32'd0);
      check_val("abort_hits", {16'b0, hit_count}, 32'd0);
      check_val("abort_misses", {16'b0, miss_count}, 32'd0);
      check_val("abort_mem_addr", mem_addr, 32'd0);
      cpu_req = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      line_word.delete();
      line_val.delete();
      exp_hits   = 0;
      exp_misses = 0;
      access(1'b0, 32'h0000_1C04, 32'h0, 2);   // previously hit, now misses
      access(1'b0, 32'h0000_2C04, 32'h0, 1);   // abandoned fill left nothing

      finish_up();
   end

endmodule
